instr_encoder_loader: RTL and testbench

- Inverse of the opcode-to-control decoder: takes decoded instruction fields (class, registers, immediates) over a valid/ready stream and encodes them into 32-bit MIPS instruction words.
- Writes each encoded word sequentially into instruction memory.
- Used by the bench and boot path to load programs for the single-cycle datapath.
- Supported set: R-type, addi, ori, andi, lw, sw, slti, beq, bne, bgtz, j.

---
 rtl/instr_encoder_loader_pkg.sv | 61 ++++++
 rtl/instr_field_encoder.sv | 31 +++
 rtl/instr_encoder_loader.sv | 128 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the instruction encoder/loader: class codes, MIPS opcodes, FSM states, field bundle.
package instr_encoder_loader_pkg;

  localparam int unsigned CLS_W = 4;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;
  localparam int unsigned IMM_W = 16;
  localparam int unsigned TGT_W = 26;

  // Decoded instruction class codes carried on the input stream
  localparam logic [CLS_W-1:0] CLS_R    = 4'd0;
  localparam logic [CLS_W-1:0] CLS_ADDI = 4'd1;
  localparam logic [CLS_W-1:0] CLS_ORI  = 4'd2;
  localparam logic [CLS_W-1:0] CLS_ANDI = 4'd3;
  localparam logic [CLS_W-1:0] CLS_LW   = 4'd4;
  localparam logic [CLS_W-1:0] CLS_SW   = 4'd5;
  localparam logic [CLS_W-1:0] CLS_SLTI = 4'd6;
  localparam logic [CLS_W-1:0] CLS_BEQ  = 4'd7;
  localparam logic [CLS_W-1:0] CLS_BNE  = 4'd8;
  localparam logic [CLS_W-1:0] CLS_BGTZ = 4'd9;
  localparam logic [CLS_W-1:0] CLS_J    = 4'd10;

  // Opcodes; identical to the values the control unit decodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_BGTZ  = 6'b000111;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_FULL = 2'd3
  } loadState_e;

  // One decoded-instruction beat as presented on the input stream
  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] shamt;
    logic [OP_W-1:0]  funct;
    logic [IMM_W-1:0] imm;
    logic [TGT_W-1:0] target;
  } instrFields_t;

  // Assemble an I-type word
  function automatic logic [31:0] iWord(input logic [OP_W-1:0] op, input logic [REG_W-1:0] rs,
                                        input logic [REG_W-1:0] rt, input logic [IMM_W-1:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational encoder: decoded class + fields -> 32-bit MIPS word and legality flag.
module instr_field_encoder
  import instr_encoder_loader_pkg::*;
(
  input  instrFields_t fields,
  output logic [31:0]  word_c,
  output logic         legal_c
);

  // Select the instruction format by class; unknown classes are flagged illegal
  always_comb begin
    word_c  = '0;
    legal_c = 1'b1;
    case (fields.cls)
      CLS_R:    word_c = {OP_RTYPE, fields.rs, fields.rt, fields.rd, fields.shamt, fields.funct};
      CLS_ADDI: word_c = iWord(OP_ADDI, fields.rs, fields.rt, fields.imm);
      CLS_ORI:  word_c = iWord(OP_ORI,  fields.rs, fields.rt, fields.imm);
      CLS_ANDI: word_c = iWord(OP_ANDI, fields.rs, fields.rt, fields.imm);
      CLS_LW:   word_c = iWord(OP_LW,   fields.rs, fields.rt, fields.imm);
      CLS_SW:   word_c = iWord(OP_SW,   fields.rs, fields.rt, fields.imm);
      CLS_SLTI: word_c = iWord(OP_SLTI, fields.rs, fields.rt, fields.imm);
      CLS_BEQ:  word_c = iWord(OP_BEQ,  fields.rs, fields.rt, fields.imm);
      CLS_BNE:  word_c = iWord(OP_BNE,  fields.rs, fields.rt, fields.imm);
      // bgtz has no rt operand; the field is architecturally zero
      CLS_BGTZ: word_c = iWord(OP_BGTZ, fields.rs, 5'd0, fields.imm);
      CLS_J:    word_c = {OP_J, fields.target};
      default:  legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts decoded instruction beats and writes their encodings sequentially into instruction memory.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              illegal,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  loadState_e        state, stateNext;
  logic [CNT_W-1:0]  countQ, countNext;
  logic              memWeQ, memWeNext;
  logic [ADDR_W-1:0] memAddrQ, memAddrNext;
  logic [31:0]       memWdataQ, memWdataNext;
  logic              illegalQ, illegalNext;

  instrFields_t fields;
  logic [31:0]  encWord;
  logic         encLegal;
  logic         accept;

  assign fields = '{cls: in_class, rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                    funct: in_funct, imm: in_imm, target: in_target};

  instr_field_encoder uEncoder (
    .fields  (fields),
    .word_c  (encWord),
    .legal_c (encLegal)
  );

  // Session control has priority over a concurrent beat
  assign in_ready = (state == ST_LOAD) && !start && !finish && (countQ < DEPTH_C);
  assign accept   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= stateNext;
  end

  // Next state, write generation and word counter
  always_comb begin
    stateNext    = state;
    countNext    = countQ;
    memWeNext    = 1'b0;
    memAddrNext  = memAddrQ;
    memWdataNext = memWdataQ;
    illegalNext  = 1'b0;

    if (accept) begin
      if (encLegal) begin
        memWeNext    = 1'b1;
        memAddrNext  = BASE_C + ADDR_W'(countQ);
        memWdataNext = encWord;
        countNext    = countQ + CNT_W'(1);
      end else begin
        illegalNext = 1'b1;
      end
    end

    if (start) begin
      stateNext = ST_LOAD;
      countNext = '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (finish)                    stateNext = ST_DONE;
          else if (countNext == DEPTH_C) stateNext = ST_FULL;
        end
        default: stateNext = state;
      endcase
    end
  end

  // Output and counter registers; reset drops any write issued this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      countQ    <= '0;
      memWeQ    <= 1'b0;
      memAddrQ  <= BASE_C;
      memWdataQ <= '0;
      illegalQ  <= 1'b0;
    end else begin
      countQ    <= countNext;
      memWeQ    <= memWeNext;
      memAddrQ  <= memAddrNext;
      memWdataQ <= memWdataNext;
      illegalQ  <= illegalNext;
    end
  end

  assign mem_we    = memWeQ;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;
  assign illegal   = illegalQ;
  assign count     = countQ;
  assign busy      = (state == ST_LOAD);
  assign done      = (state == ST_DONE);
  assign full      = (state == ST_FULL);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader against a behavioural loader model.
module tb_instr_encoder_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned BASE   = 0;

  logic clk = 1'b0;
  logic rst, start, finish, inValid;
  logic [3:0]  inClass;
  logic [4:0]  inRs, inRt, inRd, inShamt;
  logic [5:0]  inFunct;
  logic [15:0] inImm;
  logic [25:0] inTarget;
  logic        inReady, memWe, busy, done, full, illegal;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic [ADDR_W:0]   count;

  int nVectors = 0;
  int nMiscompares = 0;

  // Behavioural model: session phase (0 idle, 1 loading, 2 finished, 3 full) and write image
  int          mPhase = 0;
  int          mCount = 0;
  bit          mWe = 0;
  int          mAddr = BASE;
  logic [31:0] mData = '0;
  bit          mIll = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(inValid), .in_ready(inReady), .in_class(inClass),
    .in_rs(inRs), .in_rt(inRt), .in_rd(inRd), .in_shamt(inShamt),
    .in_funct(inFunct), .in_imm(inImm), .in_target(inTarget),
    .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .busy(busy), .done(done), .full(full), .illegal(illegal), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // MIPS encoding straight from the instruction formats, opcode looked up by class number
  function automatic logic [31:0] refEncode(input int cls);
    int opTab[11] = '{0, 8, 13, 12, 35, 43, 10, 4, 5, 7, 2};
    logic [4:0] rtEff;
    if (cls == 0)  return {6'd0, inRs, inRt, inRd, inShamt, inFunct};
    if (cls == 10) return {6'(opTab[10]), inTarget};
    rtEff = (cls == 9) ? 5'd0 : inRt;
    return {6'(opTab[cls]), inRs, rtEff, inImm};
  endfunction

  task automatic modelEdge(input bit took);
    if (rst) begin
      mPhase = 0; mCount = 0; mWe = 0; mAddr = BASE; mData = '0; mIll = 0;
      return;
    end
    mWe = 0; mIll = 0;
    if (took) begin
      if (int'(inClass) <= 10) begin
        mWe = 1; mAddr = BASE + mCount; mData = refEncode(int'(inClass)); mCount++;
      end else begin
        mIll = 1;
      end
    end
    if (start) begin
      mPhase = 1; mCount = 0;
    end else if (mPhase == 1 && finish) begin
      mPhase = 2;
    end else if (mPhase == 1 && mCount == DEPTH) begin
      mPhase = 3;
    end
  endtask

  task automatic checkOutputs();
    chk("mem_we",    32'(memWe),    32'(mWe));
    chk("mem_addr",  32'(memAddr),  32'(mAddr));
    chk("mem_wdata", memWdata,      mData);
    chk("count",     32'(count),    32'(mCount));
    chk("busy",      32'(busy),     32'(mPhase == 1));
    chk("done",      32'(done),     32'(mPhase == 2));
    chk("full",      32'(full),     32'(mPhase == 3));
    chk("illegal",   32'(illegal),  32'(mIll));
  endtask

  // One clock: check in_ready against current inputs, clock, then check registered outputs
  task automatic cycle();
    bit expReady;
    #1;
    expReady = (mPhase == 1) && !start && !finish && (mCount < DEPTH);
    chk("in_ready", 32'(inReady), 32'(expReady));
    @(posedge clk);
    modelEdge(expReady && inValid);
    #1;
    checkOutputs();
  endtask

  task automatic quiet();
    rst = 0; start = 0; finish = 0; inValid = 0;
  endtask

  task automatic beat(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt);
    quiet();
    inValid = 1; inClass = cls; inRs = rs; inRt = rt; inRd = rd; inShamt = sh;
    inFunct = fn; inImm = imm; inTarget = tgt;
  endtask

  task automatic doStart();
    quiet(); start = 1; cycle(); quiet();
  endtask

  initial begin
    quiet();
    inClass = '0; inRs = '0; inRt = '0; inRd = '0; inShamt = '0;
    inFunct = '0; inImm = '0; inTarget = '0;

    // Reset
    rst = 1;
    @(posedge clk);
    modelEdge(1'b0);
    #1;
    checkOutputs();
    rst = 0;
    cycle();

    // First write latency and ADDI encoding
    doStart();
    beat(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0); cycle();
    chk("addiWord", memWdata, 32'h20080005);
    chk("addiCount", 32'(count), 32'd1);
    quiet(); cycle();

    // Back-to-back beats: R, J, BEQ
    doStart();
    beat(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0); cycle();
    chk("rWord", memWdata, 32'h00221820);
    beat(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010); cycle();
    chk("jWord", memWdata, 32'h08000010);
    chk("jAddr", 32'(memAddr), 32'd1);
    beat(4'd7, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0); cycle();
    chk("beqWord", memWdata, 32'h1022FFFF);
    chk("beqWe", 32'(memWe), 32'd1);
    quiet(); cycle();

    // BGTZ clears rt
    doStart();
    beat(4'd9, 5'd4, 5'd7, 5'd0, 5'd0, 6'd0, 16'd3, 26'd0); cycle();
    chk("bgtzWord", memWdata, 32'h1C800003);

    // Illegal class then ADDI
    doStart();
    beat(4'd12, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1); cycle();
    chk("illPulse", 32'(illegal), 32'd1);
    chk("illNoWe", 32'(memWe), 32'd0);
    beat(4'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0); cycle();
    chk("postIllAddr", 32'(memAddr), 32'd0);
    chk("postIllCount", 32'(count), 32'd1);

    // Fill to DEPTH, fifth beat stalls, restart
    doStart();
    for (int i = 0; i < 5; i++) begin
      beat(4'd2, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'd0, 16'(i * 3), 26'd0); cycle();
    end
    chk("fullFlag", 32'(full), 32'd1);
    chk("fullReady", 32'(inReady), 32'd0);
    chk("fullAddr", 32'(memAddr), 32'(DEPTH - 1));
    quiet(); finish = 1; cycle();
    chk("fullIgnoresFinish", 32'(full), 32'd1);
    doStart();
    chk("restartCount", 32'(count), 32'd0);
    beat(4'd3, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0); cycle();
    chk("restartAddr", 32'(memAddr), 32'd0);

    // start concurrent with a beat: not accepted
    beat(4'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd9, 26'd0); start = 1; cycle();
    chk("startBeatNoWe", 32'(memWe), 32'd0);
    chk("startBeatCount", 32'(count), 32'd0);

    // finish -> DONE
    quiet(); finish = 1; cycle();
    chk("finishDone", 32'(done), 32'd1);
    quiet(); cycle();

    // Reset in the cycle after an accept
    doStart();
    beat(4'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd8, 26'd0); cycle();
    quiet(); rst = 1; cycle();
    chk("rstWe", 32'(memWe), 32'd0);
    chk("rstCount", 32'(count), 32'd0);
    chk("rstIdle", 32'(busy), 32'd0);
    quiet(); cycle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      quiet();
      rst      = ($urandom_range(0, 99) < 2);
      start    = ($urandom_range(0, 99) < 8);
      finish   = ($urandom_range(0, 99) < 5);
      inValid  = ($urandom_range(0, 99) < 70);
      inClass  = 4'($urandom_range(0, 15));
      inRs     = 5'($urandom);
      inRt     = 5'($urandom);
      inRd     = 5'($urandom);
      inShamt  = 5'($urandom);
      inFunct  = 6'($urandom);
      inImm    = 16'($urandom);
      inTarget = 26'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
